sprite_parse_list: RTL
======================

SPRITE_PARSE_LIST -- requirements
Module: sprite_parse_list

Interface
REQ-001 SHALL have parameter NUM_SPR, default 381: sprite entries scanned per line.
REQ-002 SHALL have parameter IDX_W, default 9: sprite index width, with 2^IDX_W >= NUM_SPR.
REQ-003 SHALL have parameter LIST_DEPTH, default 96: active-list capacity per line.
REQ-004 SHALL have parameter LOOKAHEAD, default 2: lines ahead of LINE that are evaluated.
REQ-005 SHALL have parameter STOP_ON_FULL, default 1: 1 = stop scan when the list is full, 0 = keep scanning and only count drops.
REQ-006 CLK  in  1  single clock; all state on its rising edge.
REQ-007 RESET  in  1  reset, asynchronous and active-high (one clock; reset is asynchronous and active-high).
REQ-008 CE  in  1  clock enable; the FSM advances only on cycles with CE=1.
REQ-009 NEW_LINE  in  1  one-cycle line-start strobe; not gated by CE.
REQ-010 LINE  in  9  current raster line, sampled on NEW_LINE.
REQ-011 FLIP  in  1  vertical flip, sampled on NEW_LINE.
REQ-012 ATTR_ADDR  out  IDX_W  sprite index being fetched.
REQ-013 ATTR_RD  out  1  read request; held until ATTR_ACK.
REQ-014 ATTR_ACK  in  1  read done; ATTR_DATA valid in the same cycle.
REQ-015 ATTR_DATA  in  16  {Y[15:7], CHAIN[6], SIZE[5:0]}.
REQ-016 RD_ADDR  in  clog2(LIST_DEPTH)  render-side list address.
REQ-017 RD_DATA  out  IDX_W  registered list entry.
REQ-018 RD_COUNT  out  clog2(LIST_DEPTH+1)  entry count of the completed list.
REQ-019 OVERFLOW  out  1  the completed list dropped at least one match.
REQ-020 ABORTED  out  1  the completed list was cut short by NEW_LINE.
REQ-021 BUSY  out  1  a scan is in progress.

Function
REQ-022 SHALL keep two list banks (ping-pong); the write bank is built while the read bank is served to RD_*.
REQ-023 On NEW_LINE SHALL, in one cycle: swap banks; latch the write count and flags into RD_COUNT/OVERFLOW/ABORTED; set TGT = LINE+LOOKAHEAD mod 512, inverted when FLIP=1; clear index, count and flags; enter FETCH.
REQ-024 FSM states SHALL be IDLE, FETCH, EVAL, DONE: FETCH asserts ATTR_RD with ATTR_ADDR=index until ATTR_ACK and registers ATTR_DATA; EVAL decides, writes and increments the index; the last index, or full with STOP_ON_FULL=1, goes to DONE; DONE holds until NEW_LINE.
REQ-025 The match test SHALL be (TGT - Y) mod 512 < SIZE*16 (10-bit compare), or true when SIZE[5]=1.
REQ-026 An entry with CHAIN=1 SHALL take the previous entry's decision, not its own test; CHAIN=1 on index 0 SHALL count as no match.
REQ-027 A matching entry SHALL write its index at the write-bank address count, then count increments; at most one write per EVAL.
REQ-028 A match with count = LIST_DEPTH SHALL not write, SHALL set the overflow flag, and SHALL stop or continue the scan per STOP_ON_FULL.
REQ-029 NEW_LINE in FETCH or EVAL SHALL abort: set ABORTED for the swapped list, RD_COUNT = entries written, drop any pending fetch, then restart per REQ-023.
REQ-030 ATTR_ACK outside FETCH SHALL be ignored; ATTR_RD SHALL drop the cycle after ACK.
REQ-031 RD_DATA SHALL be RD_ADDR's read-bank entry one cycle later; RD_ADDR >= RD_COUNT gives an undefined value; the read bank SHALL never change between swaps.
REQ-032 A NEW_LINE coinciding with the final EVAL write SHALL keep that write and SHALL not set ABORTED.
REQ-033 Minimum scan time with ACK the cycle after request and CE=1 SHALL be 3*NUM_SPR cycles.

Reset
REQ-034 RESET SHALL force IDLE, index/count 0, bank select 0, RD_COUNT 0, OVERFLOW 0, ABORTED 0, BUSY 0, ATTR_RD 0, RD_DATA 0; list RAM contents need not be cleared.
REQ-035 Reset mid-scan SHALL drop the scan; the first NEW_LINE after reset starts normally.

Verification
REQ-036 NUM_SPR=8, LINE=10, LOOKAHEAD=2; sprite 3 Y=12 SIZE=1, rest SIZE=0 -> next line RD_COUNT=1, RD_DATA[0]=3, OVERFLOW=0.
REQ-037 Sprite 1 matches, sprites 2-3 CHAIN=1, sprite 4 CHAIN=0 with no match -> list {1,2,3}, count 3.
REQ-038 LIST_DEPTH=4, all 8 SIZE[5]=1, STOP_ON_FULL=1 -> count 4, list {0,1,2,3}, OVERFLOW=1, DONE before the last index is fetched.
REQ-039 NEW_LINE after 2 of 5 matches are written -> RD_COUNT=2, ABORTED=1; the new scan restarts at index 0.
REQ-040 Random ACK delay of 0-5 cycles and CE toggling -> list matches the software model; ATTR_RD stays high until ACK.
REQ-041 Y=508 SIZE=1, TGT=2 -> match (wrap); TGT=12 -> no match.

Source files
------------

// File: rtl/sprite_parse_list.sv
// sprite_parse_list: scans the sprite attribute table once per raster line and
// builds a ping-pong list of the sprites that cover the target line.
//   CLK, RESET        clock, asynchronous active-high reset
//   CE                clock enable for the scan FSM
//   NEW_LINE          line-start strobe (not gated by CE): swaps banks, restarts the scan
//   LINE, FLIP        raster line and vertical flip, sampled on NEW_LINE
//   ATTR_ADDR/RD/ACK/DATA  attribute fetch handshake, DATA = {Y[15:7], CHAIN[6], SIZE[5:0]}
//   RD_ADDR, RD_DATA  render-side read of the completed list (one-cycle latency)
//   RD_COUNT          entries in the completed list
//   OVERFLOW, ABORTED completed list dropped a match / was cut short by NEW_LINE
//   BUSY              a scan is in progress
module sprite_parse_list #(
  parameter int NUM_SPR      = 381,
  parameter int IDX_W        = 9,
  parameter int LIST_DEPTH   = 96,
  parameter int LOOKAHEAD    = 2,
  parameter int STOP_ON_FULL = 1
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              CE,
  input  logic                              NEW_LINE,
  input  logic [8:0]                        LINE,
  input  logic                              FLIP,
  output logic [IDX_W-1:0]                  ATTR_ADDR,
  output logic                              ATTR_RD,
  input  logic                              ATTR_ACK,
  input  logic [15:0]                       ATTR_DATA,
  input  logic [$clog2(LIST_DEPTH)-1:0]     RD_ADDR,
  output logic [IDX_W-1:0]                  RD_DATA,
  output logic [$clog2(LIST_DEPTH+1)-1:0]   RD_COUNT,
  output logic                              OVERFLOW,
  output logic                              ABORTED,
  output logic                              BUSY
);
  localparam int AW = $clog2(LIST_DEPTH);
  localparam int CW = $clog2(LIST_DEPTH+1);
  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0] cnt;
  logic [8:0] tgt, y_diff;
  logic [15:0] attr;
  logic got, prev, ovf, bsel;
  logic own_hit, hit, full, last, do_eval, do_wr, drop, finish, ack_now, abort_now;
  logic [IDX_W-1:0] mem [2][LIST_DEPTH];
  // distance below the sprite top, wrapping at 512; SIZE[5] marks a full-height sprite
  assign y_diff = tgt - attr[15:7];
  assign own_hit = attr[5] | ({1'b0, y_diff} < {attr[5:0], 4'b0000});
  // a chained entry inherits its predecessor's decision; nothing precedes index 0
  assign hit = attr[6] ? (|idx && prev) : own_hit;
  assign full = cnt == CW'(LIST_DEPTH);
  assign last = idx == IDX_W'(NUM_SPR - 1);
  assign do_eval = state == EVAL && CE;
  assign do_wr = do_eval && hit && !full;
  assign drop = do_eval && hit && full;
  assign finish = last || (hit && full && STOP_ON_FULL != 0);
  // the fetched word is captured even with CE low so a one-shot ACK is never lost
  assign ack_now = state == FETCH && !got && ATTR_ACK;
  // a NEW_LINE landing on the final EVAL completes the list rather than aborting it
  assign abort_now = state == FETCH || (state == EVAL && !(CE && finish));
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = NEW_LINE ? FETCH :
                !CE ? state :
                state == FETCH ? ((got || ATTR_ACK) ? EVAL : FETCH) :
                state == EVAL ? (finish ? DONE : FETCH) : state;
  always_comb begin
    ATTR_RD = state == FETCH && !got;
    BUSY = state == FETCH || state == EVAL;
    ATTR_ADDR = idx;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      bsel <= 1'b0;
      idx <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      prev <= 1'b0;
      got <= 1'b0;
      tgt <= '0;
      attr <= '0;
      RD_COUNT <= '0;
      OVERFLOW <= 1'b0;
      ABORTED <= 1'b0;
      RD_DATA <= '0;
    end else begin
      RD_DATA <= mem[~bsel][RD_ADDR];
      if (NEW_LINE) begin
        bsel <= ~bsel;
        RD_COUNT <= cnt + CW'(do_wr);
        OVERFLOW <= ovf | drop;
        ABORTED <= abort_now;
        tgt <= (LINE + 9'(LOOKAHEAD)) ^ {9{FLIP}};
        idx <= '0;
        cnt <= '0;
        ovf <= 1'b0;
        prev <= 1'b0;
        got <= 1'b0;
      end else begin
        if (ack_now) begin
          attr <= ATTR_DATA;
          got <= 1'b1;
        end
        if (do_eval) begin
          got <= 1'b0;
          prev <= hit;
          cnt <= cnt + CW'(do_wr);
          ovf <= ovf | drop;
          idx <= finish ? idx : idx + IDX_W'(1);
        end
      end
    end
  // the write still targets the old bank on a coinciding NEW_LINE
  always_ff @(posedge CLK)
    if (do_wr) mem[bsel][cnt[AW-1:0]] <= idx;
endmodule
